// File: rtl/ring_reader.sv
// Ring buffer sweeper: presents each ring entry for dwell_len cycles, and
// services single random-read peeks that pre-empt the sweep between entries.
module ring_reader #(
  parameter int DWELL_W      = 16,
  parameter int PEEK_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell_len,
  input  logic [13:0]        ring_dout,
  input  logic               ring_ready,
  input  logic [6:0]         ring_index,
  input  logic [6:0]         ring_count,
  output logic               ring_rd_en,
  output logic [6:0]         ring_rand_addr,
  output logic               ring_rand_en,
  input  logic               ring_rand_valid,
  output logic [13:0]        freq_out,
  output logic [6:0]         ch_out,
  output logic               freq_valid,
  output logic               freq_strobe,
  output logic               sweep_done,
  input  logic               peek_req,
  input  logic [6:0]         peek_addr,
  output logic               peek_ack,
  output logic [13:0]        peek_data,
  output logic               peek_err
);
  typedef enum logic [2:0] {IDLE, FETCH, DWELL, PEEK_ISSUE, PEEK_WAIT} state_t;
  localparam int TW = $clog2(PEEK_TIMEOUT + 1);

  state_t             state;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [TW-1:0]      tcnt;
  logic               peek_go;
  logic               have_entries;

  // peek_req is still high in the ack cycle; masking it there prevents a
  // completed peek from immediately re-triggering itself.
  assign peek_go      = peek_req & ~peek_ack;
  assign have_entries = ring_count != 7'd0;
  assign ring_rd_en   = ~rst & (state == FETCH) & ring_ready & ~peek_go & have_entries;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      dwell_cnt      <= '0;
      tcnt           <= '0;
      ring_rand_addr <= '0;
      ring_rand_en   <= 1'b0;
      freq_out       <= '0;
      ch_out         <= '0;
      freq_valid     <= 1'b0;
      freq_strobe    <= 1'b0;
      sweep_done     <= 1'b0;
      peek_ack       <= 1'b0;
      peek_data      <= '0;
      peek_err       <= 1'b0;
    end else begin
      freq_strobe  <= 1'b0;
      sweep_done   <= 1'b0;
      ring_rand_en <= 1'b0;
      peek_ack     <= 1'b0;
      peek_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (peek_go)                  state <= PEEK_ISSUE;
          else if (run && have_entries) state <= FETCH;
        end
        FETCH: begin
          if (peek_go) begin
            state <= PEEK_ISSUE;
          end else if (ring_rd_en) begin
            freq_out    <= ring_dout;
            ch_out      <= ring_index;
            freq_valid  <= 1'b1;
            freq_strobe <= 1'b1;
            sweep_done  <= ring_index == (ring_count - 7'd1);
            dwell_cnt   <= (dwell_len == '0) ? '0 : dwell_len - DWELL_W'(1);
            state       <= DWELL;
          end else if (!have_entries && !run) begin
            state <= IDLE;
          end
        end
        DWELL: begin
          if (dwell_cnt == '0) begin
            if (peek_go)  state <= PEEK_ISSUE;
            else if (run) state <= FETCH;
            else          state <= IDLE;
          end else begin
            dwell_cnt <= dwell_cnt - DWELL_W'(1);
          end
        end
        PEEK_ISSUE: begin
          if (ring_ready) begin
            ring_rand_addr <= peek_addr;
            ring_rand_en   <= 1'b1;
            tcnt           <= '0;
            state          <= PEEK_WAIT;
          end
        end
        PEEK_WAIT: begin
          if (ring_rand_valid) begin
            peek_data <= ring_dout;
            peek_ack  <= 1'b1;
            state     <= run ? FETCH : IDLE;
          end else if (tcnt == TW'(PEEK_TIMEOUT - 1)) begin
            peek_ack <= 1'b1;
            peek_err <= 1'b1;
            state    <= run ? FETCH : IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ring_reader.sv
// Scoreboard bench for ring_reader: a ring model feeds the DUT, directed steps
// push expected strobes/peek acks, a negedge monitor pops and compares them.
module tb_ring_reader;
  logic        clk = 1'b0;
  logic        rst, run, ring_ready, ring_rand_valid, peek_req;
  logic [15:0] dwell_len;
  logic [13:0] ring_dout, freq_out, peek_data;
  logic [6:0]  ring_index, ring_count, ring_rand_addr, ch_out, peek_addr;
  logic        ring_rd_en, ring_rand_en, freq_valid, freq_strobe, sweep_done, peek_ack, peek_err;

  ring_reader #(.DWELL_W(16), .PEEK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .run(run), .dwell_len(dwell_len), .ring_dout(ring_dout),
    .ring_ready(ring_ready), .ring_index(ring_index), .ring_count(ring_count),
    .ring_rd_en(ring_rd_en), .ring_rand_addr(ring_rand_addr), .ring_rand_en(ring_rand_en),
    .ring_rand_valid(ring_rand_valid), .freq_out(freq_out), .ch_out(ch_out),
    .freq_valid(freq_valid), .freq_strobe(freq_strobe), .sweep_done(sweep_done),
    .peek_req(peek_req), .peek_addr(peek_addr), .peek_ack(peek_ack),
    .peek_data(peek_data), .peek_err(peek_err));

  always #5 clk = ~clk;

  // ring buffer model
  logic [13:0] mem [128];
  logic [6:0]  front = 7'd0;
  int          rand_delay = 0;
  int          rv_cnt = -1;
  assign ring_index      = front;
  assign ring_rand_valid = (rv_cnt == 0);
  assign ring_dout       = ring_rand_valid ? mem[ring_rand_addr] : mem[front];

  always @(posedge clk) begin
    if (ring_rd_en) front <= (front + 7'd1 == ring_count) ? 7'd0 : front + 7'd1;
    if (ring_rand_en && rand_delay > 0) rv_cnt <= rand_delay - 1;
    else if (rv_cnt > 0)                rv_cnt <= rv_cnt - 1;
    else                                rv_cnt <= -1;
  end

  typedef struct { logic [13:0] f; logic [6:0] ch; logic sw; int gap; } sexp_t;
  typedef struct { logic [13:0] d; logic e; int gap; } pexp_t;
  sexp_t sq[$];
  pexp_t pq[$];

  int total = 0, bad = 0;
  int cyc = 0, last_strobe = 0, rand_cyc = 0;
  int strobe_seen = 0, ack_seen = 0, rand_seen = 0, rd_cnt = 0, rd_in_peek = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    sexp_t s;
    pexp_t p;
    cyc++;
    if (ring_rd_en) rd_cnt++;
    if (peek_req && !peek_ack && ring_rd_en) rd_in_peek++;
    if (ring_rand_en) begin
      rand_seen++;
      rand_cyc = cyc;
      chk("rand_addr", 32'(ring_rand_addr), 32'(peek_addr));
    end
    if (sweep_done && !freq_strobe) chk("sweep_without_strobe", 1, 0);
    if (freq_strobe) begin
      strobe_seen++;
      if (sq.size() == 0) chk("unexpected_strobe", 1, 0);
      else begin
        s = sq.pop_front();
        chk("freq_out", 32'(freq_out), 32'(s.f));
        chk("ch_out", 32'(ch_out), 32'(s.ch));
        chk("sweep_done", 32'(sweep_done), 32'(s.sw));
        chk("freq_valid", 32'(freq_valid), 1);
        if (s.gap != 0) chk("fetch_period", 32'(cyc - last_strobe), 32'(s.gap));
      end
      last_strobe = cyc;
    end
    if (peek_ack) begin
      ack_seen++;
      if (pq.size() == 0) chk("unexpected_ack", 1, 0);
      else begin
        p = pq.pop_front();
        chk("peek_data", 32'(peek_data), 32'(p.d));
        chk("peek_err", 32'(peek_err), 32'(p.e));
        chk("peek_latency", 32'(cyc - rand_cyc), 32'(p.gap));
        chk("rd_en_during_peek", 32'(rd_in_peek), 0);
      end
      rd_in_peek = 0;
    end
  end

  task automatic push_s(input logic [13:0] f, input logic [6:0] ch, input logic sw, input int gap);
    sexp_t s;
    s.f = f; s.ch = ch; s.sw = sw; s.gap = gap;
    sq.push_back(s);
  endtask

  task automatic push_p(input logic [13:0] d, input logic e, input int gap);
    pexp_t p;
    p.d = d; p.e = e; p.gap = gap;
    pq.push_back(p);
  endtask

  // sel: 0 strobes, 1 acks, 2 rand_en; returns at negedge+1 of the event cycle
  task automatic wait_ev(input int sel, input int target);
    int v;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      v = (sel == 0) ? strobe_seen : (sel == 1) ? ack_seen : rand_seen;
      if (v >= target) return;
    end
    chk("wait_timeout", 32'(sel), 32'hFFFF);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int r0, a0;
    for (int i = 0; i < 128; i++) mem[i] = 14'h0;
    mem[0] = 14'h100; mem[1] = 14'h200; mem[2] = 14'h300; mem[5] = 14'h2AB;
    rst = 1; run = 0; ring_ready = 1; peek_req = 0; peek_addr = 0;
    dwell_len = 16'd4; ring_count = 7'd3;
    idle(3);
    chk("rst_freq_valid", 32'(freq_valid), 0);
    chk("rst_freq_strobe", 32'(freq_strobe), 0);
    chk("rst_rd_en", 32'(ring_rd_en), 0);
    chk("rst_rand_en", 32'(ring_rand_en), 0);
    chk("rst_peek_ack", 32'(peek_ack), 0);
    chk("rst_freq_out", 32'(freq_out), 0);
    chk("rst_peek_data", 32'(peek_data), 0);
    rst = 0;
    idle(2);

    // sweep with dwell 4
    push_s(14'h100, 0, 0, 0); push_s(14'h200, 1, 0, 5);
    push_s(14'h300, 2, 1, 5); push_s(14'h100, 0, 0, 5);
    run = 1;
    wait_ev(0, strobe_seen + 4);
    run = 0;
    idle(8);
    chk("idle_freq_valid_held", 32'(freq_valid), 1);
    chk("idle_freq_out_held", 32'(freq_out), 32'h100);

    // dwell 0 behaves like dwell 1
    dwell_len = 16'd0;
    push_s(14'h200, 1, 0, 0); push_s(14'h300, 2, 1, 2); push_s(14'h100, 0, 0, 2);
    run = 1;
    wait_ev(0, strobe_seen + 3);
    run = 0;
    idle(4);
    dwell_len = 16'd1;
    push_s(14'h200, 1, 0, 0); push_s(14'h300, 2, 1, 2);
    run = 1;
    wait_ev(0, strobe_seen + 2);
    run = 0;
    idle(4);

    // ring not ready for 10 cycles
    ring_ready = 0; run = 1; r0 = rd_cnt;
    idle(10);
    chk("stall_no_rd_en", 32'(rd_cnt - r0), 0);
    chk("stall_freq_held", 32'(freq_out), 32'h300);
    push_s(14'h100, 0, 0, 0);
    ring_ready = 1;
    wait_ev(0, strobe_seen + 1);
    run = 0;
    idle(4);

    // peek with data 3 cycles after the request; peek wins over run
    rand_delay = 3; peek_addr = 7'd5;
    push_p(14'h2AB, 0, 4);
    push_s(14'h200, 1, 0, 0);
    peek_req = 1; run = 1;
    wait_ev(1, ack_seen + 1);
    peek_req = 0; run = 0;
    wait_ev(0, strobe_seen + 1);
    idle(4);

    // peek that never returns data
    rand_delay = 0; peek_addr = 7'd7;
    push_p(14'h2AB, 1, 8);
    peek_req = 1;
    wait_ev(1, ack_seen + 1);
    peek_req = 0;
    idle(4);
    chk("peek_data_held", 32'(peek_data), 32'h2AB);

    // reset in the middle of a dwell
    dwell_len = 16'd20;
    push_s(14'h300, 2, 1, 0);
    run = 1;
    wait_ev(0, strobe_seen + 1);
    idle(3);
    rst = 1; run = 0;
    idle(1);
    chk("rst_dwell_freq_valid", 32'(freq_valid), 0);
    chk("rst_dwell_freq_out", 32'(freq_out), 0);
    chk("rst_dwell_ch_out", 32'(ch_out), 0);
    chk("rst_dwell_peek_data", 32'(peek_data), 0);
    chk("rst_dwell_rand_addr", 32'(ring_rand_addr), 0);
    rst = 0;
    idle(3);

    // reset during PEEK_WAIT; the late random-read data must not ack
    rand_delay = 5; peek_addr = 7'd5; a0 = ack_seen;
    peek_req = 1;
    wait_ev(2, rand_seen + 1);
    rst = 1;
    idle(1);
    rst = 0; peek_req = 0;
    idle(12);
    chk("late_valid_no_ack", 32'(ack_seen - a0), 0);
    chk("late_valid_peek_data", 32'(peek_data), 0);

    chk("strobe_queue_drained", 32'(sq.size()), 0);
    chk("peek_queue_drained", 32'(pq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ring_reader.md
RING_READER -- requirements
Module: ring_reader

Interface
REQ-001 Parameter DWELL_W, 16, width of dwell_len.
REQ-002 Parameter PEEK_TIMEOUT, 8, max cycles from ring_rand_en to ring_rand_valid before a peek errors out.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 run  in  1  level; 1 = sweep the ring, 0 = stop after current dwell.
REQ-006 dwell_len  in  DWELL_W  cycles each entry is presented; sampled at each fetch; 0 treated as 1.
REQ-007 ring_dout  in  14  front entry / random-read data from the ring buffer.
REQ-008 ring_ready  in  1  ring buffer can accept rd_en or a random read.
REQ-009 ring_index  in  7  ring slot of the front entry.
REQ-010 ring_count  in  7  number of valid ring entries.
REQ-011 ring_rd_en  out  1  advance ring by one entry.
REQ-012 ring_rand_addr  out  7  random-read slot address.
REQ-013 ring_rand_en  out  1  random-read request, one-cycle pulse.
REQ-014 ring_rand_valid  in  1  ring_dout holds random-read data this cycle.
REQ-015 freq_out  out  14  current entry value.
REQ-016 ch_out  out  7  ring slot of freq_out.
REQ-017 freq_valid  out  1  freq_out/ch_out are valid.
REQ-018 freq_strobe  out  1  one-cycle pulse when freq_out takes a new value.
REQ-019 sweep_done  out  1  one-cycle pulse when the fetched slot is ring_count-1.
REQ-020 peek_req  in  1  request random read of peek_addr; held until peek_ack.
REQ-021 peek_addr  in  7  slot to peek.
REQ-022 peek_ack  out  1  one-cycle pulse, peek complete.
REQ-023 peek_data  out  14  peeked value, valid with peek_ack, held afterwards.
REQ-024 peek_err  out  1  valid with peek_ack; 1 = timeout, peek_data unchanged.

Function
REQ-025 FSM states: IDLE, FETCH, DWELL, PEEK_ISSUE, PEEK_WAIT.
REQ-026 IDLE: run=1 and ring_count!=0 -> FETCH; peek_req=1 -> PEEK_ISSUE (peek wins over run).
REQ-027 FETCH: peek_req=1 -> PEEK_ISSUE; else if ring_ready=1 and ring_count!=0: ring_rd_en=1 this cycle, capture ring_dout->freq_out, ring_index->ch_out, load dwell counter with max(dwell_len,1)-1, freq_valid=1 and freq_strobe=1 next cycle, -> DWELL.
REQ-028 ring_rd_en is combinational from FETCH & ring_ready & ~peek_req & ring_count!=0; it is never asserted in any other state.
REQ-029 sweep_done pulses in the same cycle as freq_strobe when the captured ring_index equals ring_count-1 (7-bit compare, ring_count sampled at fetch).
REQ-030 DWELL: decrement counter each cycle; at 0: peek_req -> PEEK_ISSUE, else run=1 -> FETCH, else -> IDLE; freq_out/ch_out/freq_valid held throughout.
REQ-031 PEEK_ISSUE: wait for ring_ready=1, then register peek_addr into ring_rand_addr and pulse ring_rand_en one cycle, clear timeout counter, -> PEEK_WAIT.
REQ-032 PEEK_WAIT: ring_rand_valid=1 -> peek_data<=ring_dout, peek_ack=1, peek_err=0 next cycle; timeout counter reaches PEEK_TIMEOUT -> peek_ack=1, peek_err=1; then run=1 -> FETCH, else -> IDLE.
REQ-033 Peek does not alter freq_out, ch_out or freq_valid; a peek taken from DWELL end defers the next fetch until peek completes.
REQ-034 ring_count becoming 0 while in FETCH: stay in FETCH, no ring_rd_en, until count!=0 or run=0 (-> IDLE).
REQ-035 run deasserted mid-DWELL: dwell completes normally, freq_valid stays 1 in IDLE with last value.
REQ-036 Single outstanding peek; peek_req during PEEK_WAIT for a new address is ignored until peek_ack.

Reset
REQ-037 rst=1: state IDLE; ring_rd_en, ring_rand_en, freq_valid, freq_strobe, sweep_done, peek_ack, peek_err = 0; freq_out, ch_out, peek_data, ring_rand_addr, counters = 0.
REQ-038 Reset mid-DWELL or mid-PEEK_WAIT aborts immediately; a late ring_rand_valid after reset is ignored.

Verification
REQ-039 ring_count=3, ring_ready=1, run=1, dwell_len=4, slots 0..2 = 0x100,0x200,0x300 -> ring_rd_en every 5 cycles, freq_out 0x100,0x200,0x300,0x100..., sweep_done with ch_out=2.
REQ-040 dwell_len=0 -> fetch every 2 cycles, identical to dwell_len=1.
REQ-041 peek_req, peek_addr=5, ring_rand_valid 3 cycles after ring_rand_en, ring_dout=0x2AB -> peek_ack with peek_data=0x2AB, peek_err=0; no ring_rd_en during peek.
REQ-042 peek with ring_rand_valid never asserted -> peek_ack, peek_err=1 after 8 cycles, peek_data unchanged.
REQ-043 ring_ready=0 for 10 cycles in FETCH -> no ring_rd_en, freq_out held; resumes on ready.
REQ-044 rst asserted mid-DWELL -> next cycle all outputs at reset values, state IDLE.
